alsu_pipe: RTL and testbench

Parametrised, pipelined successor to the team's 3-bit ALSU. Arithmetic/logic/shift unit with generic operand width, an input valid qualifier with matching output valid, and a saturating invalid-operation counter alongside the LED blink indication. Sits behind the ALSU test interface as a drop-in upgrade. With default parameters it is cycle-compatible with the existing ALSU at the out/leds level when in_valid is held high.

---
 rtl/alsu_pkg.sv | 43 ++++
 rtl/alsu_ops.sv | 70 +++++++
 rtl/alsu_pipe.sv | 128 ++++++++++++
 tb/tb_alsu_pipe.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alsu_pkg.sv
// Shared types for the pipelined ALSU: opcode and priority encodings, the
// stage-1 control bundle, and the invalid-operation rule.
package alsu_pkg;

  typedef enum logic [2:0] {
    OP_OR     = 3'd0,
    OP_XOR    = 3'd1,
    OP_ADD    = 3'd2,
    OP_MULT   = 3'd3,
    OP_SHIFT  = 3'd4,
    OP_ROTATE = 3'd5,
    OP_INV6   = 3'd6,
    OP_INV7   = 3'd7
  } opcode_e;

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } priority_e;

  typedef struct packed {
    logic    cin;
    logic    serial_in;
    logic    direction;
    logic    red_op_a;
    logic    red_op_b;
    logic    bypass_a;
    logic    bypass_b;
    opcode_e opcode;
  } ctrl_t;

  // Reductions are only meaningful for OR/XOR; any other opcode with a
  // reduction flag is rejected, as are the two unused opcodes.
  function automatic logic is_invalid(input opcode_e opcode,
                                      input logic    red_op_a,
                                      input logic    red_op_b);
    logic red_any;
    red_any = red_op_a | red_op_b;
    return (opcode == OP_INV6) || (opcode == OP_INV7) ||
           (red_any && (opcode != OP_OR) && (opcode != OP_XOR));
  endfunction

endpackage

// File: rtl/alsu_ops.sv
// Combinational datapath: maps the stage-1 operands/controls plus the current
// result register to the next result and an invalid-operation flag.
module alsu_ops
  import alsu_pkg::*;
#(
  parameter int    WIDTH          = 3,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               cin_i,
  input  logic               serial_in_i,
  input  logic               direction_i,
  input  logic               red_op_a_i,
  input  logic               red_op_b_i,
  input  logic               bypass_a_i,
  input  logic               bypass_b_i,
  input  logic [2:0]         opcode_i,
  input  logic [2*WIDTH-1:0] out_cur_i,
  output logic [2*WIDTH-1:0] out_next_o,
  output logic               invalid_o
);

  localparam int        OW      = 2 * WIDTH;
  localparam priority_e PRI     = (INPUT_PRIORITY == "B") ? PRI_B : PRI_A;
  localparam logic      ADD_CIN = (FULL_ADDER == "ON");

  opcode_e          op;
  logic [OW-1:0]    a_ext;
  logic [OW-1:0]    b_ext;
  logic             red_any;
  logic             sel_b_byp;
  logic             sel_b_red;
  logic [WIDTH-1:0] red_src;

  assign op        = opcode_e'(opcode_i);
  assign a_ext     = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign b_ext     = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign red_any   = red_op_a_i | red_op_b_i;
  // B wins only when it is the sole flag, or both are set and priority is B.
  assign sel_b_byp = bypass_b_i & (~bypass_a_i | (PRI == PRI_B));
  assign sel_b_red = red_op_b_i & (~red_op_a_i | (PRI == PRI_B));
  assign red_src   = sel_b_red ? b_i : a_i;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    out_next_o = '0;
    invalid_o  = 1'b0;
    if (bypass_a_i || bypass_b_i) begin
      out_next_o = sel_b_byp ? b_ext : a_ext;
    end else if (is_invalid(op, red_op_a_i, red_op_b_i)) begin
      invalid_o = 1'b1;
    end else begin
      case (op)
        OP_OR:     out_next_o = red_any ? OW'(|red_src) : (a_ext | b_ext);
        OP_XOR:    out_next_o = red_any ? OW'(^red_src) : (a_ext ^ b_ext);
        OP_ADD:    out_next_o = a_ext + b_ext + OW'(cin_i & ADD_CIN);
        OP_MULT:   out_next_o = a_ext * b_ext;
        OP_SHIFT:  out_next_o = direction_i ? {out_cur_i[OW-2:0], serial_in_i}
                                            : {serial_in_i, out_cur_i[OW-1:1]};
        OP_ROTATE: out_next_o = direction_i ? {out_cur_i[OW-2:0], out_cur_i[OW-1]}
                                            : {out_cur_i[0], out_cur_i[OW-1:1]};
        default:   out_next_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/alsu_pipe.sv
// Two-stage pipelined ALSU: stage 1 registers qualified inputs, stage 2
// registers the result, valid pulse, LED blink pattern and error counter.
module alsu_pipe
  import alsu_pkg::*;
#(
  parameter int    WIDTH          = 3,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    LED_W          = 16,
  parameter int    ERRCNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      cin,
  input  logic                      serial_in,
  input  logic                      direction,
  input  logic                      red_op_A,
  input  logic                      red_op_B,
  input  logic                      bypass_A,
  input  logic                      bypass_B,
  input  logic [2:0]                opcode,
  input  logic signed [WIDTH-1:0]   A,
  input  logic signed [WIDTH-1:0]   B,
  output logic signed [2*WIDTH-1:0] out,
  output logic                      out_valid,
  output logic [LED_W-1:0]          leds,
  output logic [ERRCNT_W-1:0]       err_count
);

  ctrl_t               s1_ctrl_q, s1_ctrl_d;
  logic [WIDTH-1:0]    s1_a_q;
  logic [WIDTH-1:0]    s1_b_q;
  logic                s1_valid_q;

  logic [2*WIDTH-1:0]  out_q, out_d;
  logic                out_valid_q;
  logic [LED_W-1:0]    leds_q, leds_d;
  logic [ERRCNT_W-1:0] err_q, err_d;

  logic [2*WIDTH-1:0]  ops_out;
  logic                ops_invalid;

  assign s1_ctrl_d = '{cin:       cin,
                       serial_in: serial_in,
                       direction: direction,
                       red_op_a:  red_op_A,
                       red_op_b:  red_op_B,
                       bypass_a:  bypass_A,
                       bypass_b:  bypass_B,
                       opcode:    opcode_e'(opcode)};

  // Stage 1 keeps its operands while idle; only the valid bit drops.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_ctrl_q  <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_ctrl_q <= s1_ctrl_d;
        s1_a_q    <= A;
        s1_b_q    <= B;
      end
    end
  end

  alsu_ops #(
    .WIDTH          (WIDTH),
    .INPUT_PRIORITY (INPUT_PRIORITY),
    .FULL_ADDER     (FULL_ADDER)
  ) u_ops (
    .a_i         (s1_a_q),
    .b_i         (s1_b_q),
    .cin_i       (s1_ctrl_q.cin),
    .serial_in_i (s1_ctrl_q.serial_in),
    .direction_i (s1_ctrl_q.direction),
    .red_op_a_i  (s1_ctrl_q.red_op_a),
    .red_op_b_i  (s1_ctrl_q.red_op_b),
    .bypass_a_i  (s1_ctrl_q.bypass_a),
    .bypass_b_i  (s1_ctrl_q.bypass_b),
    .opcode_i    (s1_ctrl_q.opcode),
    .out_cur_i   (out_q),
    .out_next_o  (ops_out),
    .invalid_o   (ops_invalid)
  );

  always_comb begin
    out_d  = out_q;
    leds_d = leds_q;
    err_d  = err_q;
    if (s1_valid_q) begin
      out_d = ops_out;
      if (ops_invalid) begin
        leds_d = ~leds_q;
        if (err_q != '1) begin
          err_d = err_q + ERRCNT_W'(1);
        end
      end else begin
        leds_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      leds_q      <= '0;
      err_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= s1_valid_q;
      leds_q      <= leds_d;
      err_q       <= err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign leds      = leds_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_alsu_pipe.sv
// Scoreboard bench for alsu_pipe: two instances (priority A / full adder, and
// priority B / no carry-in) share stimulus; expected results are queued.
module tb_alsu_pipe;
  import alsu_pkg::*;

  localparam int W  = 3;
  localparam int OW = 2 * W;

  localparam logic [6:0] F_CIN = 7'b1000000;
  localparam logic [6:0] F_SI  = 7'b0100000;
  localparam logic [6:0] F_DIR = 7'b0010000;
  localparam logic [6:0] F_RA  = 7'b0001000;
  localparam logic [6:0] F_RB  = 7'b0000100;
  localparam logic [6:0] F_BA  = 7'b0000010;
  localparam logic [6:0] F_BB  = 7'b0000001;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         cin, si, dir, ra, rb, ba, bb;
  } stim_t;

  typedef struct {
    logic [OW-1:0] out_a;
    logic [OW-1:0] out_b;
    logic [15:0]   leds;
    logic [7:0]    err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic cin = 1'b0, serial_in = 1'b0, direction = 1'b0;
  logic red_op_A = 1'b0, red_op_B = 1'b0, bypass_A = 1'b0, bypass_B = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic signed [W-1:0] A = '0, B = '0;

  logic signed [OW-1:0] out_a, out_b;
  logic                 valid_a, valid_b;
  logic [15:0]          leds_a, leds_b;
  logic [7:0]           err_a, err_b;

  exp_t          exp_q[$];
  logic [OW-1:0] m_out_a, m_out_b;
  logic [15:0]   m_leds;
  logic [7:0]    m_err;
  int            vectors = 0;
  int            miscompares = 0;

  alsu_pipe dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cin(cin), .serial_in(serial_in),
    .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B), .opcode(opcode), .A(A), .B(B),
    .out(out_a), .out_valid(valid_a), .leds(leds_a), .err_count(err_a)
  );

  alsu_pipe #(.INPUT_PRIORITY("B"), .FULL_ADDER("OFF")) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cin(cin), .serial_in(serial_in),
    .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B), .opcode(opcode), .A(A), .B(B),
    .out(out_b), .out_valid(valid_b), .leds(leds_b), .err_count(err_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [OW-1:0] sx(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  function automatic stim_t st(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [6:0] f);
    stim_t s;
    s.op = op; s.a = a; s.b = b;
    {s.cin, s.si, s.dir, s.ra, s.rb, s.ba, s.bb} = f;
    return s;
  endfunction

  // Reference behaviour of one instance for one accepted operation.
  function automatic logic [OW-1:0] ref_out(input bit pri_b, input bit fa_on,
                                            input logic [OW-1:0] prev,
                                            input stim_t s, output bit inv);
    logic [W-1:0]  v;
    logic [OW-1:0] r;
    int            p;
    bit            red;
    inv = 1'b0;
    red = s.ra || s.rb;
    if (s.ba || s.bb) return (s.bb && (!s.ba || pri_b)) ? sx(s.b) : sx(s.a);
    if (s.op >= 3'd6 || (red && s.op > 3'd1)) begin
      inv = 1'b1;
      return '0;
    end
    v = (s.rb && (!s.ra || pri_b)) ? s.b : s.a;
    case (s.op)
      3'd0: r = red ? {{(OW-1){1'b0}}, |v} : (sx(s.a) | sx(s.b));
      3'd1: r = red ? {{(OW-1){1'b0}}, ^v} : (sx(s.a) ^ sx(s.b));
      3'd2: r = sx(s.a) + sx(s.b) + {{(OW-1){1'b0}}, fa_on & s.cin};
      3'd3: begin
        p = $signed(s.a) * $signed(s.b);
        r = p[OW-1:0];
      end
      3'd4: r = s.dir ? {prev[OW-2:0], s.si} : {s.si, prev[OW-1:1]};
      default: r = s.dir ? {prev[OW-2:0], prev[OW-1]} : {prev[0], prev[OW-1:1]};
    endcase
    return r;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   inv_a, inv_b;
    @(negedge clk);
    in_valid = 1'b1;
    A = s.a; B = s.b; opcode = s.op;
    cin = s.cin; serial_in = s.si; direction = s.dir;
    red_op_A = s.ra; red_op_B = s.rb; bypass_A = s.ba; bypass_B = s.bb;
    m_out_a = ref_out(1'b0, 1'b1, m_out_a, s, inv_a);
    m_out_b = ref_out(1'b1, 1'b0, m_out_b, s, inv_b);
    if (inv_a) begin
      m_leds = ~m_leds;
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end else begin
      m_leds = '0;
    end
    e = '{m_out_a, m_out_b, m_leds, m_err};
    exp_q.push_back(e);
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard: every out_valid pops the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (valid_a || valid_b)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: out_valid a=%b b=%b with nothing pending", valid_a, valid_b);
      end else begin
        e = exp_q.pop_front();
        if (valid_a !== 1'b1 || valid_b !== 1'b1 || out_a !== e.out_a || out_b !== e.out_b ||
            leds_a !== e.leds || leds_b !== e.leds || err_a !== e.err || err_b !== e.err) begin
          miscompares++;
          $display("FAIL scoreboard: got v=%b%b out_a=%b out_b=%b leds=%h/%h err=%0d/%0d, required out_a=%b out_b=%b leds=%h err=%0d",
                   valid_a, valid_b, out_a, out_b, leds_a, leds_b, err_a, err_b,
                   e.out_a, e.out_b, e.leds, e.err);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if ({out_a, out_b, valid_a, valid_b, leds_a, leds_b, err_a, err_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: out=%b/%b valid=%b/%b leds=%h/%h err=%0d/%0d, required all 0",
               out_a, out_b, valid_a, valid_b, leds_a, leds_b, err_a, err_b);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_out_a = '0; m_out_b = '0; m_leds = '0; m_err = '0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_after_reset: out_valid=%b/%b, required 0", valid_a, valid_b);
      end
    end
  endtask

  task automatic test_add();
    apply(st(OP_ADD, W'(3), W'(2), F_CIN));
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (valid_a !== 1'b0) begin
      miscompares++;
      $display("FAIL add_latency_early: out_valid=%b one edge after capture, required 0", valid_a);
    end
    @(negedge clk);
    vectors++;
    if (valid_a !== 1'b1 || valid_b !== 1'b1 || out_a !== 6'sd6 || out_b !== 6'sd5) begin
      miscompares++;
      $display("FAIL add_result: valid=%b/%b out=%0d/%0d, required 1/1 6/5",
               valid_a, valid_b, out_a, out_b);
    end
    @(negedge clk);
    vectors++;
    if (valid_a !== 1'b0) begin
      miscompares++;
      $display("FAIL add_pulse: out_valid=%b after one cycle, required 0", valid_a);
    end
  endtask

  task automatic test_mult();
    apply(st(OP_MULT, W'(-4), W'(3), 7'b0));
    drain();
    vectors++;
    if (out_a !== 6'b110100 || out_b !== 6'b110100) begin
      miscompares++;
      $display("FAIL mult_neg: out=%b/%b, required 110100", out_a, out_b);
    end
    apply(st(OP_MULT, W'(-4), W'(-4), 7'b0));
    drain();
    vectors++;
    if (out_a !== 6'sd16 || out_b !== 6'sd16) begin
      miscompares++;
      $display("FAIL mult_pos: out=%0d/%0d, required 16", out_a, out_b);
    end
  endtask

  task automatic test_invalid();
    repeat (3) apply(st(OP_INV6, W'(1), W'(1), 7'b0));
    drain();
    vectors++;
    if (out_a !== '0 || leds_a !== 16'hFFFF || err_a !== 8'd3 || err_b !== 8'd3) begin
      miscompares++;
      $display("FAIL invalid_burst: out=%0d leds=%h err=%0d/%0d, required 0 ffff 3",
               out_a, leds_a, err_a, err_b);
    end
    apply(st(OP_XOR, W'(1), W'(2), 7'b0));
    drain();
    vectors++;
    if (out_a !== 6'sd3 || leds_a !== 16'h0 || leds_b !== 16'h0 || err_a !== 8'd3) begin
      miscompares++;
      $display("FAIL invalid_recover: out=%0d leds=%h/%h err=%0d, required 3 0000 3",
               out_a, leds_a, leds_b, err_a);
    end
  endtask

  task automatic test_shift_rotate();
    apply(st(OP_OR, W'(3), W'(0), F_BA));
    apply(st(OP_SHIFT, W'(0), W'(0), F_DIR));
    apply(st(OP_SHIFT, W'(0), W'(0), F_DIR | F_SI));
    apply(st(OP_ROTATE, W'(0), W'(0), 7'b0));
    drain();
    vectors++;
    if (out_a !== 6'b100110 || out_b !== 6'b100110) begin
      miscompares++;
      $display("FAIL shift_rotate_chain: out=%b/%b, required 100110", out_a, out_b);
    end
    apply(st(OP_ROTATE, W'(0), W'(0), F_DIR));
    apply(st(OP_SHIFT, W'(0), W'(0), F_SI));
    apply(st(OP_SHIFT, W'(0), W'(0), 7'b0));
    drain();
  endtask

  task automatic test_priority();
    apply(st(OP_OR, W'(-1), W'(2), F_BA | F_BB));
    drain();
    vectors++;
    if (out_a !== 6'b111111 || out_b !== 6'b000010) begin
      miscompares++;
      $display("FAIL bypass_priority: out=%b/%b, required 111111/000010", out_a, out_b);
    end
    apply(st(OP_OR, W'(0), W'(3), F_RA | F_RB));
    drain();
    vectors++;
    if (out_a !== 6'd0 || out_b !== 6'd1) begin
      miscompares++;
      $display("FAIL reduce_priority: out=%0d/%0d, required 0/1", out_a, out_b);
    end
    apply(st(OP_XOR, W'(-1), W'(3), F_RA | F_RB));
    apply(st(OP_XOR, W'(2), W'(-1), F_RB));
    apply(st(OP_ADD, W'(1), W'(1), F_RA));
    apply(st(OP_INV7, W'(-2), W'(1), F_BB));
    drain();
  endtask

  task automatic test_back_to_back();
    stim_t s;
    for (int i = 0; i < 40; i++) begin
      s.a   = W'($urandom_range(0, 7));
      s.b   = W'($urandom_range(0, 7));
      s.op  = 3'($urandom_range(0, 7));
      s.cin = 1'($urandom_range(0, 1));
      s.si  = 1'($urandom_range(0, 1));
      s.dir = 1'($urandom_range(0, 1));
      s.ra  = ($urandom_range(0, 3) == 0);
      s.rb  = ($urandom_range(0, 3) == 0);
      s.ba  = ($urandom_range(0, 7) == 0);
      s.bb  = ($urandom_range(0, 7) == 0);
      apply(s);
      if (i >= 2) begin
        vectors++;
        if (valid_a !== 1'b1 || valid_b !== 1'b1) begin
          miscompares++;
          $display("FAIL back_to_back_valid: op %0d out_valid=%b/%b, required 1", i, valid_a, valid_b);
        end
      end
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    apply(st(OP_OR, W'(3), W'(0), F_BA));
    drain();
    apply(st(OP_ADD, W'(1), W'(1), 7'b0));
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    exp_q.delete();
    m_out_a = '0; m_out_b = '0; m_leds = '0; m_err = '0;
    vectors++;
    if (out_a !== '0 || out_b !== '0 || valid_a !== 1'b0 || err_a !== '0 || leds_a !== '0) begin
      miscompares++;
      $display("FAIL reset_async: out=%0d/%0d valid=%b err=%0d leds=%h, required all 0",
               out_a, out_b, valid_a, err_a, leds_a);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (valid_a !== 1'b0 || valid_b !== 1'b0 || out_a !== '0) begin
        miscompares++;
        $display("FAIL reset_flush: out_valid=%b/%b out=%0d, required 0 0", valid_a, valid_b, out_a);
      end
    end
    apply(st(OP_ADD, W'(1), W'(1), F_CIN));
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (valid_a !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_early: out_valid=%b, required 0", valid_a);
    end
    @(negedge clk);
    vectors++;
    if (valid_a !== 1'b1 || out_a !== 6'sd3 || out_b !== 6'sd2) begin
      miscompares++;
      $display("FAIL post_reset_latency: valid=%b out=%0d/%0d, required 1 3/2", valid_a, out_a, out_b);
    end
    drain();
  endtask

  task automatic test_saturation();
    repeat (300) apply(st(OP_INV7, W'(0), W'(0), 7'b0));
    drain();
    vectors++;
    if (err_a !== 8'hFF || err_b !== 8'hFF || leds_a !== 16'h0 || out_a !== '0) begin
      miscompares++;
      $display("FAIL err_saturate: err=%0d/%0d leds=%h out=%0d, required 255 0000 0",
               err_a, err_b, leds_a, out_a);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mult();
    test_invalid();
    test_shift_rotate();
    test_priority();
    test_back_to_back();
    test_reset_midstream();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
